// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte (LSB first, odd parity, stop) on device clock falls
// and checks the device acknowledge. Both pads are driven open-drain via *Oe.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] TxByte,
    input  logic       ClockKeyboard,
    input  logic       DataKeyboard,
    output logic       ClockKeyboardOe,
    output logic       DataKeyboardOe,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        XFER,
        WAIT_IDLE,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [3:0]         k_q, k_d;
    logic [7:0]         tx_q, tx_d;
    logic               par_q, par_d;
    logic               data_oe_q, data_oe_d;
    logic               err_q, err_d;

    logic               clk_meta_q, clk_sync_q;
    logic               dat_meta_q, dat_sync_q;
    logic [FLT_W-1:0]   flt_cnt_q;
    logic               clk_flt_q, clk_flt_prev_q;
    logic               fall;
    logic               timeout;

    // Two-flop synchronizers; idle bus level is high, so reset to 1.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ClockKeyboard;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= DataKeyboard;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Accept a new clock level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            flt_cnt_q      <= '0;
            clk_flt_q      <= 1'b1;
            clk_flt_prev_q <= 1'b1;
        end else begin
            clk_flt_prev_q <= clk_flt_q;
            if (clk_sync_q == clk_flt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                clk_flt_q <= clk_sync_q;
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    assign fall    = clk_flt_prev_q & ~clk_flt_q;
    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // FSM state, counters and the latched command byte.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            k_q       <= '0;
            tx_q      <= '0;
            par_q     <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            k_q       <= k_d;
            tx_q      <= tx_d;
            par_q     <= par_d;
            data_oe_q <= data_oe_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic and line/handshake outputs.
    always_comb begin
        state_d         = state_q;
        inh_cnt_d       = inh_cnt_q;
        to_cnt_d        = to_cnt_q;
        k_d             = k_q;
        tx_d            = tx_q;
        par_d           = par_q;
        data_oe_d       = data_oe_q;
        err_d           = err_q;
        ClockKeyboardOe = 1'b0;
        DataKeyboardOe  = 1'b0;
        Busy            = 1'b1;
        Done            = 1'b0;
        Error           = 1'b0;

        unique case (state_q)
            IDLE: begin
                Busy      = 1'b0;
                data_oe_d = 1'b0;
                if (Start) begin
                    tx_d      = TxByte;
                    par_d     = ~^TxByte;
                    err_d     = 1'b0;
                    inh_cnt_d = '0;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                ClockKeyboardOe = 1'b1;
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    // Start bit goes out together with the last inhibit cycle.
                    DataKeyboardOe = 1'b1;
                    data_oe_d      = 1'b1;
                    to_cnt_d       = '0;
                    k_d            = '0;
                    state_d        = XFER;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            XFER: begin
                DataKeyboardOe = data_oe_q;
                to_cnt_d       = to_cnt_q + 1'b1;
                if (timeout) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = FINISH;
                end else if (fall) begin
                    // k_q is the count before this fall, so it indexes data bit k-1.
                    k_d = k_q + 4'd1;
                    if (k_q < 4'd8) begin
                        data_oe_d = ~tx_q[k_q[2:0]];
                    end else if (k_q == 4'd8) begin
                        data_oe_d = ~par_q;
                    end else if (k_q == 4'd9) begin
                        data_oe_d = 1'b0;
                    end else begin
                        data_oe_d = 1'b0;
                        if (dat_sync_q) begin
                            err_d   = 1'b1;
                            state_d = FINISH;
                        end else begin
                            state_d = WAIT_IDLE;
                        end
                    end
                end
            end

            WAIT_IDLE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else if (clk_sync_q && dat_sync_q) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                Done      = 1'b1;
                Error     = err_q;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out of the
// host, captures it, and the captured frame is compared with the expected one.
module tb_ps2_host_tx;

    localparam int unsigned INH = 20;
    localparam int unsigned TO  = 3000;
    localparam int unsigned FLT = 2;

    logic        Clock  = 1'b0;
    logic        Reset  = 1'b0;
    logic        Start  = 1'b0;
    logic [7:0]  TxByte = 8'h00;
    logic        ClockKeyboardOe, DataKeyboardOe, Busy, Done, Error;
    logic        dev_clk_low  = 1'b0;
    logic        dev_data_low = 1'b0;
    logic        line_clk, line_data;
    logic [10:0] dev_cap;
    int          n_checks = 0;
    int          n_errors = 0;

    // Open-drain bus with pull-ups.
    assign line_clk  = ~(ClockKeyboardOe | dev_clk_low);
    assign line_data = ~(DataKeyboardOe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FLT)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start          (Start),
        .TxByte         (TxByte),
        .ClockKeyboard  (line_clk),
        .DataKeyboard   (line_data),
        .ClockKeyboardOe(ClockKeyboardOe),
        .DataKeyboardOe (DataKeyboardOe),
        .Busy           (Busy),
        .Done           (Done),
        .Error          (Error)
    );

    always #5 Clock = ~Clock;

    // Device: 100-cycle clock period, samples data on rising edges.
    // mode 0 = ACK, 1 = no ACK, 2 = ACK with a Start pulse mid-frame, 3 = reset at k=5.
    task automatic device(input int mode);
        dev_cap = '0;
        repeat (30) @(posedge Clock);
        for (int i = 1; i <= 11; i++) begin
            dev_clk_low = 1'b1;
            repeat (25) @(posedge Clock);
            if (mode == 2 && i == 5) begin
                #1;
                TxByte = 8'h00;
                Start  = 1'b1;
                @(posedge Clock);
                #1 Start = 1'b0;
            end
            if (mode == 3 && i == 5) begin
                @(negedge Clock);
                #2 Reset = 1'b0;
                #1;
                n_checks++;
                if (ClockKeyboardOe !== 1'b0 || DataKeyboardOe !== 1'b0) begin
                    n_errors++;
                    $display("FAIL reset_mid_lines: got clkoe=%b dataoe=%b want 0 0",
                             ClockKeyboardOe, DataKeyboardOe);
                end
                n_checks++;
                if (Busy !== 1'b0 || Done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL reset_mid_busy: got busy=%b done=%b want 0 0", Busy, Done);
                end
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                return;
            end
            repeat (25) @(posedge Clock);
            dev_clk_low    = 1'b0;
            dev_cap[i - 1] = line_data;
            repeat (25) @(posedge Clock);
            if (i == 10 && mode != 1) dev_data_low = 1'b1;
            if (i == 11) dev_data_low = 1'b0;
            repeat (25) @(posedge Clock);
        end
    endtask

    // Pulse Start and check the inhibit window and the start bit.
    task automatic begin_xfer(input logic [7:0] b, input string name);
        int   hi       = 0;
        int   doe_cnt  = 0;
        logic doe_last = 1'b0;
        TxByte = b;
        Start  = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        n_checks++;
        if (Busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_busy_on_start: got %b want 1", name, Busy);
        end
        while (ClockKeyboardOe === 1'b1 && hi < 200) begin
            hi++;
            if (DataKeyboardOe === 1'b1) doe_cnt++;
            doe_last = DataKeyboardOe;
            @(negedge Clock);
        end
        n_checks++;
        if (hi != INH) begin
            n_errors++;
            $display("FAIL %s_inhibit_len: got %0d want %0d", name, hi, INH);
        end
        n_checks++;
        if (doe_cnt != 1 || doe_last !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_start_bit_timing: got cnt=%0d last=%b want 1 1",
                     name, doe_cnt, doe_last);
        end
        n_checks++;
        if (DataKeyboardOe !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_start_bit_held: got %b want 1", name, DataKeyboardOe);
        end
    endtask

    // Wait for Done and check the completion handshake.
    task automatic monitor(input int budget, input logic exp_err, input bit sif,
                           input string name, output int cyc);
        cyc = 0;
        while (Done !== 1'b1 && cyc < budget) begin
            @(negedge Clock);
            cyc++;
        end
        n_checks++;
        if (Done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_done_seen: got %b want 1 within %0d cycles", name, Done, budget);
        end else begin
            n_checks++;
            if (Error !== exp_err) begin
                n_errors++;
                $display("FAIL %s_error: got %b want %b", name, Error, exp_err);
            end
            n_checks++;
            if (ClockKeyboardOe !== 1'b0 || DataKeyboardOe !== 1'b0 || Busy !== 1'b1) begin
                n_errors++;
                $display("FAIL %s_finish_lines: got clkoe=%b dataoe=%b busy=%b want 0 0 1",
                         name, ClockKeyboardOe, DataKeyboardOe, Busy);
            end
            if (sif) begin
                TxByte = 8'h55;
                Start  = 1'b1;
            end
            @(negedge Clock);
            Start = 1'b0;
            n_checks++;
            if (Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0) begin
                n_errors++;
                $display("FAIL %s_after_done: got busy=%b done=%b err=%b want 0 0 0",
                         name, Busy, Done, Error);
            end
            @(negedge Clock);
            n_checks++;
            if (Busy !== 1'b0 || ClockKeyboardOe !== 1'b0) begin
                n_errors++;
                $display("FAIL %s_stays_idle: got busy=%b clkoe=%b want 0 0",
                         name, Busy, ClockKeyboardOe);
            end
        end
    endtask

    // Full transaction; mode 4 means the device never answers.
    task automatic do_xfer(input logic [7:0] b, input int mode, input bit sif,
                           input string name);
        int   cyc;
        logic expp;
        // Odd parity: the parity bit makes the total count of ones odd.
        expp = (($countones(b) % 2) == 0);
        begin_xfer(b, name);
        if (mode == 4) begin
            monitor(TO + 500, 1'b1, sif, name, cyc);
            n_checks++;
            if (cyc != TO) begin
                n_errors++;
                $display("FAIL %s_timeout_cycles: got %0d want %0d", name, cyc, TO);
            end
        end else begin
            fork
                device(mode);
                monitor(2500, (mode == 1), sif, name, cyc);
            join
            n_checks++;
            if (dev_cap[7:0] !== b) begin
                n_errors++;
                $display("FAIL %s_data: got %h want %h", name, dev_cap[7:0], b);
            end
            n_checks++;
            if (dev_cap[8] !== expp) begin
                n_errors++;
                $display("FAIL %s_parity: got %b want %b", name, dev_cap[8], expp);
            end
            n_checks++;
            if (dev_cap[9] !== 1'b1) begin
                n_errors++;
                $display("FAIL %s_stop: got %b want 1", name, dev_cap[9]);
            end
        end
        repeat (10) @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        n_checks++;
        if ({ClockKeyboardOe, DataKeyboardOe, Busy, Done, Error} !== 5'b00000) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {ClockKeyboardOe, DataKeyboardOe, Busy, Done, Error});
        end
        Reset = 1'b1;
        repeat (5) @(negedge Clock);
        n_checks++;
        if ({ClockKeyboardOe, DataKeyboardOe, Busy, Done, Error} !== 5'b00000) begin
            n_errors++;
            $display("FAIL idle_outputs: got %b want 00000",
                     {ClockKeyboardOe, DataKeyboardOe, Busy, Done, Error});
        end
    endtask

    task automatic test_nominal();
        do_xfer(8'hED, 0, 1'b1, "nominal_ed");
    endtask

    task automatic test_parity();
        do_xfer(8'hF4, 0, 1'b0, "parity_f4");
        do_xfer(8'h00, 0, 1'b0, "parity_00");
    endtask

    task automatic test_no_ack();
        do_xfer(8'hF4, 1, 1'b0, "no_ack");
    endtask

    task automatic test_timeout();
        do_xfer(8'hED, 4, 1'b0, "timeout");
    endtask

    task automatic test_restart_ignored();
        do_xfer(8'hED, 2, 1'b0, "restart_ignored");
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        begin_xfer(8'hA5, "reset_mid");
        device(3);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clock);
            if (Done !== 1'b0 || Busy !== 1'b0 || ClockKeyboardOe !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", seen);
        end
        do_xfer(8'hFF, 0, 1'b0, "after_reset_ff");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         mode;
        for (int i = 0; i < 6; i++) begin
            b    = 8'($urandom);
            mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            do_xfer(b, mode, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_parity();
        test_no_ack();
        test_timeout();
        test_restart_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
